// File: rtl/writeback_unit_pkg.sv
// Shared constants and types for the writeback unit.
// Optional feature switch: WB_BYPASS_EN (adds a same-cycle bypass from the write port).
package writeback_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One candidate write towards the register file.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] r);
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy mask of registers with a load in flight, plus the outstanding-load counter.
module wb_scoreboard
  import writeback_unit_pkg::*;
#(
  parameter int unsigned MAX_LD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_dst,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_dst,
  output logic                  ready,
  output logic [NREG-1:0]       busy_mask
);

  localparam int unsigned CntW = $clog2(MAX_LD + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LD);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inc, dec;

  assign ready     = cnt_q < MaxCnt;
  assign busy_mask = busy_q;

  // Next-state for busy bits and counter; a set beats a clear of the same register.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    // Issue while full is dropped entirely.
    inc    = set_en & ready;
    // Spurious return with nothing outstanding leaves the counter at zero.
    dec    = clr_en & (cnt_q != '0);
    if (clr_en) busy_d[clr_dst] = 1'b0;
    if (inc && !is_zero_reg(set_dst)) busy_d[set_dst] = 1'b1;
    busy_d[0] = 1'b0;
    unique case ({inc, clr_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = dec ? cnt_q - 1'b1 : cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write master: arbitrates load returns over ALU results, drives the
// registered write port, and tracks in-flight loads for RAW stalls in decode.
// Optional feature: define WB_BYPASS_EN to expose a combinational bypass of the write port.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned MAX_LD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dst,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_dst,
  output logic                  ld_issue_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_dst,
  input  logic [XLEN-1:0]       ld_data,
  output logic [NREG-1:0]       busy_mask,
`ifdef WB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] byp_addr1,
  input  logic [REG_ADDR_W-1:0] byp_addr2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [XLEN-1:0]       byp_data1,
  output logic [XLEN-1:0]       byp_data2,
`endif
  output logic [REG_ADDR_W-1:0] dstreg_addr,
  output logic                  write_reg,
  output logic [XLEN-1:0]       dstreg_data
);

  wb_req_t               sel;
  logic                  write_d;
  logic [REG_ADDR_W-1:0] addr_d;
  logic [XLEN-1:0]       data_d;

  // Load returns cannot be back-pressured, so the ALU waits whenever one arrives.
  assign alu_ready = ~ld_valid;

  // Fixed-priority arbiter and next-state of the write port.
  always_comb begin
    sel = '0;
    if (ld_valid) begin
      sel = '{valid: 1'b1, dst: ld_dst, data: ld_data};
    end else if (alu_valid) begin
      sel = '{valid: 1'b1, dst: alu_dst, data: alu_data};
    end
    // x0 results are consumed but never written.
    write_d = sel.valid & ~is_zero_reg(sel.dst);
    addr_d  = write_d ? sel.dst : dstreg_addr;
    data_d  = write_d ? sel.data : dstreg_data;
  end

  // Registered write port, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_reg   <= 1'b0;
      dstreg_addr <= REG_ZERO;
      dstreg_data <= '0;
    end else begin
      write_reg   <= write_d;
      dstreg_addr <= addr_d;
      dstreg_data <= data_d;
    end
  end

  wb_scoreboard #(
    .MAX_LD (MAX_LD)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (ld_issue),
    .set_dst   (ld_issue_dst),
    .clr_en    (ld_valid),
    .clr_dst   (ld_dst),
    .ready     (ld_issue_ready),
    .busy_mask (busy_mask)
  );

`ifdef WB_BYPASS_EN
  // Forward the pending write while it is not yet visible in the regfile.
  assign byp_hit1  = write_reg & (dstreg_addr == byp_addr1) & ~is_zero_reg(byp_addr1);
  assign byp_hit2  = write_reg & (dstreg_addr == byp_addr2) & ~is_zero_reg(byp_addr2);
  assign byp_data1 = dstreg_data;
  assign byp_data2 = dstreg_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected regfile writes go through a queue,
// popped by a monitor whenever write_reg is seen; other outputs are checked inline.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        ld_issue, ld_issue_ready;
  logic [4:0]  ld_issue_dst;
  logic        ld_valid;
  logic [4:0]  ld_dst;
  logic [31:0] ld_data;
  logic [31:0] busy_mask;
  logic [4:0]  dstreg_addr;
  logic        write_reg;
  logic [31:0] dstreg_data;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_addr1, byp_addr2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_busy;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_dst        (alu_dst),
    .alu_data       (alu_data),
    .ld_issue       (ld_issue),
    .ld_issue_dst   (ld_issue_dst),
    .ld_issue_ready (ld_issue_ready),
    .ld_valid       (ld_valid),
    .ld_dst         (ld_dst),
    .ld_data        (ld_data),
    .busy_mask      (busy_mask),
`ifdef WB_BYPASS_EN
    .byp_addr1      (byp_addr1),
    .byp_addr2      (byp_addr2),
    .byp_hit1       (byp_hit1),
    .byp_hit2       (byp_hit2),
    .byp_data1      (byp_data1),
    .byp_data2      (byp_data2),
`endif
    .dstreg_addr    (dstreg_addr),
    .write_reg      (write_reg),
    .dstreg_data    (dstreg_data)
  );

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && write_reg !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        assert (write_reg === 1'b0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr=%0d data=%h, expected no write",
                 dstreg_addr, dstreg_data);
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        assert ({dstreg_addr, dstreg_data} === {e.addr, e.data}) else begin
          errors++;
          $error("FAIL write_port: observed addr=%0d data=%h, expected addr=%0d data=%h",
                 dstreg_addr, dstreg_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_issue  = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic issue(input logic [4:0] d);
    ld_issue     = 1'b1;
    ld_issue_dst = d;
    cyc();
    ld_issue = 1'b0;
  endtask

  task automatic ret(input logic [4:0] d, input logic [31:0] v);
    ld_valid = 1'b1;
    ld_dst   = d;
    ld_data  = v;
    if (d != 5'd0) exp_q.push_back('{addr: d, data: v});
    cyc();
    ld_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    alu_dst = '0; alu_data = '0; ld_issue_dst = '0; ld_dst = '0; ld_data = '0;
`ifdef WB_BYPASS_EN
    byp_addr1 = '0; byp_addr2 = '0;
`endif
    exp_busy = '0;

    // Reset with a load issue held active.
    ld_issue = 1'b1; ld_issue_dst = 5'd9;
    cyc(); cyc();
    chk("rst_busy", 64'(busy_mask), 64'(0));
    chk("rst_write_reg", 64'(write_reg), 64'(0));
    chk("rst_ready", 64'(ld_issue_ready), 64'(1));
    chk("rst_addr", 64'(dstreg_addr), 64'(0));
    chk("rst_data", 64'(dstreg_data), 64'(0));
    ld_issue = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Plain ALU write.
    alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'hDEADBEEF;
    #1 chk("alu_ready_idle", 64'(alu_ready), 64'(1));
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    cyc();
    alu_valid = 1'b0;
    chk("alu_wr_n1", 64'(write_reg), 64'(1));
    cyc();
    chk("alu_wr_n2", 64'(write_reg), 64'(0));

    // Collision: load wins, ALU held until accepted.
    alu_valid = 1'b1; alu_dst = 5'd12; alu_data = 32'hA5A5A5A5;
    ld_valid = 1'b1; ld_dst = 5'd7; ld_data = 32'h1234;
    #1 chk("alu_ready_coll", 64'(alu_ready), 64'(0));
    exp_q.push_back('{addr: 5'd7, data: 32'h1234});
    cyc();
    ld_valid = 1'b0;
    chk("coll_first_addr", 64'(dstreg_addr), 64'(7));
    #1 chk("alu_ready_after", 64'(alu_ready), 64'(1));
    exp_q.push_back('{addr: 5'd12, data: 32'hA5A5A5A5});
    cyc();
    alu_valid = 1'b0;
    chk("coll_second_addr", 64'(dstreg_addr), 64'(12));
    cyc();

    // Scoreboard set, then simultaneous set and clear on the same register.
    issue(5'd9);
    exp_busy[9] = 1'b1;
    chk("busy_set9", 64'(busy_mask), 64'(exp_busy));
    ld_issue = 1'b1; ld_issue_dst = 5'd9;
    ret(5'd9, 32'h99);
    ld_issue = 1'b0;
    chk("busy_setwins", 64'(busy_mask), 64'(exp_busy));
    ret(5'd9, 32'h98);
    exp_busy[9] = 1'b0;
    chk("busy_clr9", 64'(busy_mask), 64'(exp_busy));
    chk("ready_after9", 64'(ld_issue_ready), 64'(1));

    // Fill to the outstanding limit; the fifth issue is dropped.
    issue(5'd1); issue(5'd2); issue(5'd4);
    chk("ready_at3", 64'(ld_issue_ready), 64'(1));
    issue(5'd6);
    exp_busy = 32'h0000_0056;
    chk("ready_full", 64'(ld_issue_ready), 64'(0));
    issue(5'd3);
    chk("busy_drop3", 64'(busy_mask), 64'(exp_busy));
    // ALU write to a busy register goes through and leaves busy alone.
    alu_valid = 1'b1; alu_dst = 5'd4; alu_data = 32'hCAFE0004;
    exp_q.push_back('{addr: 5'd4, data: 32'hCAFE0004});
    cyc();
    alu_valid = 1'b0;
    chk("busy_alu_keep", 64'(busy_mask), 64'(exp_busy));
    ret(5'd1, 32'h11);
    exp_busy[1] = 1'b0;
    chk("ready_after_ret", 64'(ld_issue_ready), 64'(1));
    chk("busy_clr1", 64'(busy_mask), 64'(exp_busy));
    ret(5'd2, 32'h22); ret(5'd4, 32'h44); ret(5'd6, 32'h66);
    chk("busy_empty", 64'(busy_mask), 64'(0));

    // x0: counted but never busy and never written.
    issue(5'd0);
    chk("x0_busy_issue", 64'(busy_mask), 64'(0));
    ret(5'd0, 32'hFFFF_0000);
    chk("x0_busy_ret", 64'(busy_mask), 64'(0));
    cyc();
    chk("x0_no_write", 64'(write_reg), 64'(0));
    // Counter back at zero: exactly four more issues fill it.
    issue(5'd10); issue(5'd11); issue(5'd12);
    chk("x0_cnt_ready3", 64'(ld_issue_ready), 64'(1));
    issue(5'd13);
    chk("x0_cnt_full4", 64'(ld_issue_ready), 64'(0));
    chk("busy_10_13", 64'(busy_mask), 64'(32'h0000_3C00));
    ret(5'd10, 32'hA); ret(5'd11, 32'hB); ret(5'd12, 32'hC); ret(5'd13, 32'hD);
    chk("busy_final", 64'(busy_mask), 64'(0));

    // Spurious return with nothing outstanding still writes; counter stays at zero.
    ret(5'd20, 32'h2020_2020);
    chk("spur_ready", 64'(ld_issue_ready), 64'(1));

    cyc(); cyc();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
